game_digit_entry: RTL and testbench

- Player-input front end for the game datapath.
- Synchronizes and debounces a raw push-button, then captures the 4-bit switch value on each confirmed press.
- Drives the load/clear/4-bit-data inputs of the downstream per-digit load registers, one single-cycle load per press.
- Counts NUM_DIGITS presses per round and flags round completion to the game controller.

---
 rtl/game_digit_entry.sv | 153 +++++++++++++++
 tb/tb_game_digit_entry.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_digit_entry.sv
// Player digit entry: synchronizes/debounces a push-button and emits one load strobe per press.
// Define ENTRY_TIMEOUT_EN to restart a partly entered round after TIMEOUT_CYCLES idle cycles.
module game_digit_entry #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_DIGITS      = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic [3:0] sw_in,
   input  logic       game_enable,
   output logic       load_out,
   output logic       clear_out,
   output logic [3:0] digit_out,
   output logic [3:0] digit_idx,
   output logic       entry_done,
   output logic       busy
);
   localparam int CNT_MAX = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
   localparam logic [3:0]    LAST_IDX = 4'(NUM_DIGITS - 1);
`ifdef ENTRY_TIMEOUT_EN
   localparam logic [CW-1:0] TO_N     = CW'(TIMEOUT_CYCLES);
`endif

   typedef enum logic [2:0] {IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE, DONE} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    sync_reg;
   logic          en_reg;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          load_reg, load_next;
   logic          clear_reg, clear_next;
   logic          done_reg, done_next;
   logic [3:0]    digit_reg, digit_next;
   logic [3:0]    idx_reg, idx_next;
   logic          btn_s;
`ifdef ENTRY_TIMEOUT_EN
   logic [CW-1:0] idle_reg, idle_next;
`endif

   assign btn_s = sync_reg[1];

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg  <= '0;
         en_reg    <= 1'b0;
         state_reg <= IDLE;
         cnt_reg   <= '0;
         load_reg  <= 1'b0;
         clear_reg <= 1'b0;
         done_reg  <= 1'b0;
         digit_reg <= '0;
         idx_reg   <= '0;
`ifdef ENTRY_TIMEOUT_EN
         idle_reg  <= '0;
`endif
      end else begin
         sync_reg  <= {sync_reg[0], btn_raw};
         en_reg    <= game_enable;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         load_reg  <= load_next;
         clear_reg <= clear_next;
         done_reg  <= done_next;
         digit_reg <= digit_next;
         idx_reg   <= idx_next;
`ifdef ENTRY_TIMEOUT_EN
         idle_reg  <= idle_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      load_next  = 1'b0;
      clear_next = 1'b0;
      done_next  = 1'b0;
      digit_next = digit_reg;
      idx_next   = idx_reg;
`ifdef ENTRY_TIMEOUT_EN
      idle_next  = '0;
`endif
      // Dropping game_enable aborts the round and wins over a press qualifying this cycle.
      if (state_reg != IDLE && !game_enable) begin
         state_next = IDLE;
         clear_next = 1'b1;
         idx_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (game_enable && !en_reg) begin
                  clear_next = 1'b1;
                  idx_next   = '0;
                  state_next = WAIT_PRESS;
               end
            end
            WAIT_PRESS: begin
               if (cnt_reg == DEB_N) begin
                  state_next = CAPTURE;
                  load_next  = 1'b1;
                  digit_next = sw_in;
                  if (idx_reg == LAST_IDX) begin
                     done_next = 1'b1;
                     idx_next  = '0;
                  end else begin
                     idx_next = idx_reg + 4'd1;
                  end
               end else if (btn_s) begin
                  cnt_next = sat_inc(cnt_reg);
`ifdef ENTRY_TIMEOUT_EN
               end else if (idx_reg != '0) begin
                  if (idle_reg == TO_N) begin
                     clear_next = 1'b1;
                     idx_next   = '0;
                  end else begin
                     idle_next = sat_inc(idle_reg);
                  end
`endif
               end
            end
            CAPTURE: state_next = WAIT_RELEASE;
            WAIT_RELEASE: begin
               // digit_idx is back at 0 after a capture only when the last digit was taken.
               if (cnt_reg == DEB_N) begin
                  state_next = (idx_reg == '0) ? DONE : WAIT_PRESS;
               end else if (!btn_s) begin
                  cnt_next = sat_inc(cnt_reg);
               end
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   assign load_out   = load_reg;
   assign clear_out  = clear_reg;
   assign entry_done = done_reg;
   assign digit_out  = digit_reg;
   assign digit_idx  = idx_reg;
   assign busy       = (state_reg == WAIT_PRESS && cnt_reg != '0) ||
                       (state_reg == CAPTURE) || (state_reg == WAIT_RELEASE);

endmodule

// File: tb/tb_game_digit_entry.sv
// Randomized press/bounce/abort stimulus for game_digit_entry checked against a round-level model.
module tb_game_digit_entry;
   localparam int D = 4;
   localparam int N = 4;
   localparam int T = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_raw = 1'b0;
   logic       game_enable = 1'b0;
   logic [3:0] sw_in = 4'h0;
   logic       load_out, clear_out, entry_done, busy;
   logic [3:0] digit_out, digit_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: digits taken this round, round open flag, last captured digit
   int         k = 0;
   bit         open = 1'b0;
   logic [3:0] last_dig = 4'h0;
   int         exp_loads = 0;

   int         load_cyc[$];
   logic [3:0] load_dig[$];
   logic       load_done[$];
   int         clear_cyc[$];
   int         overlap = 0;
   int         stray_done = 0;

   game_digit_entry #(
      .DEBOUNCE_CYCLES(D),
      .NUM_DIGITS(N),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .sw_in(sw_in),
      .game_enable(game_enable),
      .load_out(load_out),
      .clear_out(clear_out),
      .digit_out(digit_out),
      .digit_idx(digit_idx),
      .entry_done(entry_done),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (load_out) begin
         load_cyc.push_back(cyc);
         load_dig.push_back(digit_out);
         load_done.push_back(entry_done);
      end
      if (clear_out) clear_cyc.push_back(cyc);
      if (load_out && clear_out) overlap++;
      if (entry_done && !load_out) stray_done++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic raise();
      int n0, c0;
      n0 = clear_cyc.size();
      c0 = cyc;
      game_enable = 1'b1;
      repeat (3) step();
      chk("raise_clear_cnt", clear_cyc.size() - n0, 1);
      if (clear_cyc.size() > n0) chk("raise_clear_cyc", clear_cyc[n0] - c0, 1);
      chk("raise_idx", digit_idx, 0);
      k = 0;
      open = 1'b1;
      $display("enable rise at cyc %0d idx=%0d", c0, digit_idx);
   endtask

   task automatic drop();
      int n0, l0, c0;
      n0 = clear_cyc.size();
      l0 = load_cyc.size();
      c0 = cyc;
      game_enable = 1'b0;
      repeat (3) step();
      chk("drop_clear_cnt", clear_cyc.size() - n0, 1);
      if (clear_cyc.size() > n0) chk("drop_clear_cyc", clear_cyc[n0] - c0, 1);
      chk("drop_no_load", load_cyc.size() - l0, 0);
      chk("drop_idx", digit_idx, 0);
      k = 0;
      open = 1'b0;
      $display("enable drop at cyc %0d idx=%0d", c0, digit_idx);
   endtask

   task automatic press(input logic [3:0] v, input int hold, input int gap);
      int n0, c0;
      bit exp_load;
      n0 = load_cyc.size();
      exp_load = open;
      sw_in = v;
      btn_raw = 1'b1;
      c0 = cyc;
      repeat (hold) step();
      btn_raw = 1'b0;
      repeat (gap) step();
      chk("load_cnt", load_cyc.size() - n0, exp_load ? 1 : 0);
      if (exp_load && load_cyc.size() > n0) begin
         chk("load_lat", load_cyc[n0] - c0, D + 3);
         chk("load_dig", load_dig[n0], v);
         chk("done_flag", load_done[n0], (k == N - 1) ? 1 : 0);
      end
      if (exp_load) begin
         exp_loads++;
         last_dig = v;
         k++;
         if (k == N) begin
            k = 0;
            open = 1'b0;
         end
      end
      chk("idx", digit_idx, k);
      chk("dig_hold", digit_out, last_dig);
      $display("press v=%h hold=%0d load=%0d idx=%0d dig=%h", v, hold, exp_load, digit_idx, digit_out);
   endtask

   task automatic bounce_rand();
      int n0, idx0, runs;
      n0 = load_cyc.size();
      idx0 = digit_idx;
      runs = $urandom_range(1, 3);
      for (int r = 0; r < runs; r++) begin
         btn_raw = 1'b1;
         repeat ($urandom_range(1, D - 1)) step();
         btn_raw = 1'b0;
         repeat ($urandom_range(1, 3)) step();
      end
      repeat (3) step();
      chk("bounce_rand_load", load_cyc.size() - n0, 0);
      chk("bounce_rand_idx", digit_idx, idx0);
      $display("bounce runs=%0d idx=%0d", runs, digit_idx);
   endtask

   initial begin
      int pat[5];
      int n0;
      logic [3:0] rnd_v;
      pat = '{1, 0, 1, 1, 0};

      // reset state
      btn_raw = 1'b1;
      sw_in = 4'hF;
      game_enable = 1'b1;
      repeat (3) step();
      chk("rst_flags", {28'd0, load_out, clear_out, entry_done, busy}, 0);
      chk("rst_digit", digit_out, 0);
      chk("rst_idx", digit_idx, 0);
      btn_raw = 1'b0;
      game_enable = 1'b0;
      step();
      rst = 1'b1;
      repeat (2) step();
      $display("reset released at cyc %0d", cyc);

      // single press, then fixed bounce pattern
      raise();
      press(4'hA, 20, D + 4);
      n0 = load_cyc.size();
      for (int i = 0; i < 5; i++) begin
         btn_raw = pat[i][0];
         step();
      end
      btn_raw = 1'b0;
      repeat (10) step();
      chk("bounce_load", load_cyc.size() - n0, 0);
      chk("bounce_idx", digit_idx, 1);
      $display("bounce 1,0,1,1,0 idx=%0d", digit_idx);
      drop();

      // full round, then a press while DONE
      raise();
      press(4'h3, D + 5, D + 4);
      press(4'h7, D + 8, D + 5);
      press(4'h1, D + 3, D + 6);
      press(4'h9, D + 12, D + 4);
      press(4'h5, D + 10, D + 4);

      // asynchronous reset mid-run
      rst = 1'b0;
      #1;
      chk("arst_flags", {28'd0, load_out, clear_out, entry_done, busy}, 0);
      chk("arst_digit", digit_out, 0);
      chk("arst_idx", digit_idx, 0);
      $display("async reset at cyc %0d dig=%h idx=%0d", cyc, digit_out, digit_idx);
      last_dig = 4'h0;
      open = 1'b0;
      k = 0;
      game_enable = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();

      // abort during WAIT_RELEASE after two digits
      raise();
      press(4'h2, D + 4, D + 4);
      n0 = load_cyc.size();
      sw_in = 4'h6;
      btn_raw = 1'b1;
      repeat (D + 6) step();
      chk("abort_load", load_cyc.size() - n0, 1);
      chk("abort_idx_pre", digit_idx, 2);
      chk("abort_busy", busy, 1);
      exp_loads++;
      last_dig = 4'h6;
      k = 2;
      drop();
      btn_raw = 1'b0;
      repeat (6) step();
      raise();
      press(4'hC, D + 6, D + 4);
      drop();

      // idle between digits
      raise();
      press(4'h4, D + 4, D + 4);
      n0 = clear_cyc.size();
`ifdef ENTRY_TIMEOUT_EN
      repeat (T + 12) step();
      chk("timeout_clear", clear_cyc.size() - n0, 1);
      chk("timeout_idx", digit_idx, 0);
      k = 0;
`else
      repeat (200) step();
      chk("idle_clear", clear_cyc.size() - n0, 0);
      chk("idle_idx", digit_idx, 1);
`endif
      $display("idle wait done idx=%0d", digit_idx);
      drop();

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         raise();
         for (int p = 0; p < N + 1; p++) begin
            if ($urandom_range(0, 2) == 0) bounce_rand();
            rnd_v = 4'($urandom_range(0, 15));
            press(rnd_v, D + 3 + $urandom_range(0, 12), D + 4 + $urandom_range(0, 6));
            if (open && $urandom_range(0, 5) == 0) break;
         end
         drop();
      end

      chk("total_loads", load_cyc.size(), exp_loads);
      chk("load_clear_overlap", overlap, 0);
      chk("stray_done", stray_done, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
